// File: rtl/key_sw_io_device_if.sv
// Processor-side load/store bus between the CPU (MAR/DrMem/WrMem) and the KEY/SW device.
// The master drives the address and strobes; the device answers with rdata/sel.
interface key_sw_io_device_if #(
  parameter int DBITS = 32
);
  logic [DBITS-1:0] addr;
  logic [DBITS-1:0] wdata;
  logic             we;
  logic             re;
  logic [DBITS-1:0] rdata;
  logic             sel;

  modport master (
    output addr,
    output wdata,
    output we,
    output re,
    input  rdata,
    input  sel
  );

  modport slave (
    input  addr,
    input  wdata,
    input  we,
    input  re,
    output rdata,
    output sel
  );
endinterface

// File: rtl/key_sw_io_device.sv
// KEY/SW memory-mapped input device: synchronizes and debounces the board inputs and
// exposes them as data/control registers with sticky ready/overrun status and an irq.
module key_sw_io_debounce #(
  parameter int WIDTH     = 4,
  parameter int DEBCYCLES = 50000,
  parameter int CNTBITS   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] deb,
  output logic             change
);
  localparam logic [CNTBITS-1:0] CNT_LAST = CNTBITS'(DEBCYCLES - 1);

  logic [WIDTH-1:0]   meta;
  logic [WIDTH-1:0]   sync;
  logic [WIDTH-1:0]   cand;
  logic [CNTBITS-1:0] cnt;
  logic [CNTBITS-1:0] cnt_inc;

  // The capture of a new candidate counts as its first stable cycle, so acceptance
  // happens when the incremented count reaches DEBCYCLES-1 (2 sync + DEBCYCLES latency).
  always_comb begin
    cnt_inc = cnt + 1'b1;
    change  = (sync == cand) && (cand != deb) && (cnt_inc == CNT_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      sync <= '0;
      cand <= '0;
      deb  <= '0;
      cnt  <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      if (sync != cand) begin
        cand <= sync;
        cnt  <= '0;
      end else if (cand != deb) begin
        if (change) begin
          deb <= cand;
          cnt <= '0;
        end else begin
          cnt <= cnt_inc;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module key_sw_io_device #(
  parameter int               DBITS     = 32,
  parameter logic [DBITS-1:0] ADDRKEY   = DBITS'(32'hFFFFF080),
  parameter logic [DBITS-1:0] ADDRSW    = DBITS'(32'hFFFFF090),
  parameter int               DEBCYCLES = 50000,
  parameter int               CNTBITS   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  key_sw_io_device_if.slave          bus,
  input  logic [3:0]                 key_n,
  input  logic [9:0]                 sw,
  output logic                       irq
);
  localparam logic [DBITS-1:0] ADDR_KDATA = ADDRKEY;
  localparam logic [DBITS-1:0] ADDR_KCTRL = ADDRKEY + DBITS'(4);
  localparam logic [DBITS-1:0] ADDR_SDATA = ADDRSW;
  localparam logic [DBITS-1:0] ADDR_SCTRL = ADDRSW + DBITS'(4);

  logic [3:0] key_deb;
  logic       key_change;
  logic [9:0] sw_deb;
  logic       sw_change;

  logic kready, kovr, kie;
  logic sready, sovr, sie;

  logic rd_kdata, rd_sdata, wr_kctrl, wr_sctrl;
  logic unused_wdata;

  // KEY is active-low on the board; invert before syncing so 1 means pressed.
  key_sw_io_debounce #(
    .WIDTH(4), .DEBCYCLES(DEBCYCLES), .CNTBITS(CNTBITS)
  ) u_key_deb (
    .clk(clk), .reset(reset), .raw(~key_n), .deb(key_deb), .change(key_change)
  );

  key_sw_io_debounce #(
    .WIDTH(10), .DEBCYCLES(DEBCYCLES), .CNTBITS(CNTBITS)
  ) u_sw_deb (
    .clk(clk), .reset(reset), .raw(sw), .deb(sw_deb), .change(sw_change)
  );

  // A store alongside a load is treated as a store, so it never consumes ready.
  always_comb begin
    rd_kdata = bus.re && !bus.we && (bus.addr == ADDR_KDATA);
    rd_sdata = bus.re && !bus.we && (bus.addr == ADDR_SDATA);
    wr_kctrl = bus.we && (bus.addr == ADDR_KCTRL);
    wr_sctrl = bus.we && (bus.addr == ADDR_SCTRL);
  end

  assign unused_wdata = ^{bus.wdata[DBITS-1:5], bus.wdata[3], bus.wdata[1:0]};

  // A change coinciding with a data read keeps ready set and is not an overrun;
  // a change coinciding with an overrun-clearing store keeps the overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kready <= 1'b0;
      kovr   <= 1'b0;
      kie    <= 1'b0;
    end else begin
      if (key_change) begin
        kready <= 1'b1;
      end else if (rd_kdata) begin
        kready <= 1'b0;
      end
      if (key_change && kready && !rd_kdata) begin
        kovr <= 1'b1;
      end else if (wr_kctrl && !bus.wdata[2]) begin
        kovr <= 1'b0;
      end
      if (wr_kctrl) begin
        kie <= bus.wdata[4];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sready <= 1'b0;
      sovr   <= 1'b0;
      sie    <= 1'b0;
    end else begin
      if (sw_change) begin
        sready <= 1'b1;
      end else if (rd_sdata) begin
        sready <= 1'b0;
      end
      if (sw_change && sready && !rd_sdata) begin
        sovr <= 1'b1;
      end else if (wr_sctrl && !bus.wdata[2]) begin
        sovr <= 1'b0;
      end
      if (wr_sctrl) begin
        sie <= bus.wdata[4];
      end
    end
  end

  always_comb begin
    bus.rdata = '0;
    bus.sel   = 1'b0;
    case (bus.addr)
      ADDR_KDATA: begin
        bus.sel        = 1'b1;
        bus.rdata[3:0] = key_deb;
      end
      ADDR_KCTRL: begin
        bus.sel      = 1'b1;
        bus.rdata[4] = kie;
        bus.rdata[2] = kovr;
        bus.rdata[0] = kready;
      end
      ADDR_SDATA: begin
        bus.sel        = 1'b1;
        bus.rdata[9:0] = sw_deb;
      end
      ADDR_SCTRL: begin
        bus.sel      = 1'b1;
        bus.rdata[4] = sie;
        bus.rdata[2] = sovr;
        bus.rdata[0] = sready;
      end
      default: begin
        bus.sel   = 1'b0;
        bus.rdata = '0;
      end
    endcase
  end

  assign irq = (kready & kie) | (sready & sie);
endmodule

// File: tb/tb_key_sw_io_device.sv
// Scoreboard bench for key_sw_io_device: bus reads queue their expected value when driven
// and are compared when rdata is sampled; debounce timing is checked cycle by cycle.
module tb_key_sw_io_device;
  localparam int          DBITS   = 32;
  localparam int          DEB     = 4;
  localparam logic [31:0] ADDRKEY = 32'hFFFFF080;
  localparam logic [31:0] ADDRSW  = 32'hFFFFF090;
  localparam logic [31:0] KDATA   = ADDRKEY;
  localparam logic [31:0] KCTRL   = ADDRKEY + 32'd4;
  localparam logic [31:0] SDATA   = ADDRSW;
  localparam logic [31:0] SCTRL   = ADDRSW + 32'd4;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_n;
  logic [9:0] sw;
  logic       irq;

  int checks = 0;
  int passed = 0;
  sb_item_t sb[$];

  key_sw_io_device_if #(.DBITS(DBITS)) bus ();

  key_sw_io_device #(
    .DBITS(DBITS), .ADDRKEY(ADDRKEY), .ADDRSW(ADDRSW), .DEBCYCLES(DEB), .CNTBITS(8)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .key_n(key_n), .sw(sw), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic popCompare(input logic [31:0] actual);
    sb_item_t item;
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", actual, 32'hDEADBEEF);
    end else begin
      item = sb.pop_front();
      checkOutput(item.tag, actual, item.exp);
    end
  endtask

  // Combinational look at a register without a load strobe (no side effects, no clock).
  task automatic peek(input logic [31:0] a, input string tag, input logic [31:0] exp);
    bus.addr = a;
    bus.re   = 1'b0;
    sb.push_back('{tag, exp});
    #1;
    popCompare(bus.rdata);
  endtask

  // Strobed load: compare rdata, then let the edge apply the read side effect.
  task automatic loadOp(input logic [31:0] a, input string tag, input logic [31:0] exp);
    bus.addr = a;
    bus.re   = 1'b1;
    sb.push_back('{tag, exp});
    #1;
    popCompare(bus.rdata);
    @(posedge clk);
    #1;
    bus.re = 1'b0;
    @(negedge clk);
  endtask

  task automatic storeOp(input logic [31:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] k, input logic [9:0] s, input int cycles);
    key_n = k;
    sw    = s;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    key_n     = 4'hF;
    sw        = 10'h000;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.we    = 1'b0;
    bus.re    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    peek(KDATA, "rst_kdata", 32'h0);
    checkOutput("rst_sel_kdata", {31'b0, bus.sel}, 32'h1);
    peek(KCTRL, "rst_kctrl", 32'h0);
    peek(SDATA, "rst_sdata", 32'h0);
    peek(SCTRL, "rst_sctrl", 32'h0);
    checkOutput("rst_sel_sctrl", {31'b0, bus.sel}, 32'h1);
    peek(32'h0000_1000, "other_rdata", 32'h0);
    checkOutput("other_sel", {31'b0, bus.sel}, 32'h0);
    checkOutput("rst_irq", {31'b0, irq}, 32'h0);
    applyStimulus(4'hF, 10'h000, 10);
    peek(KDATA, "idle_kdata", 32'h0);

    key_n = 4'hE;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      peek(KDATA, $sformatf("lat_kdata_c%0d", i), (i >= 6) ? 32'h1 : 32'h0);
      peek(KCTRL, $sformatf("lat_kctrl_c%0d", i), (i >= 6) ? 32'h1 : 32'h0);
    end
    loadOp(KDATA, "k0_read", 32'h1);
    peek(KCTRL, "k0_ready_cleared", 32'h0);

    for (int p = 0; p < 3; p++) begin
      applyStimulus(4'hE, 10'h001, 3);
      applyStimulus(4'hE, 10'h000, 3);
    end
    applyStimulus(4'hE, 10'h000, 10);
    peek(SDATA, "glitch_sdata", 32'h0);
    peek(SCTRL, "glitch_sctrl", 32'h0);

    applyStimulus(4'hE, 10'h001, 8);
    applyStimulus(4'hE, 10'h003, 8);
    peek(SCTRL, "sw_overrun", 32'h5);
    storeOp(SCTRL, 32'h0);
    peek(SCTRL, "sovr_cleared", 32'h1);
    loadOp(SDATA, "sw_read", 32'h3);
    peek(SCTRL, "sready_cleared", 32'h0);
    checkOutput("sw_irq_off", {31'b0, irq}, 32'h0);

    storeOp(KCTRL, 32'h10);
    peek(KCTRL, "kie_set", 32'h10);
    checkOutput("kie_irq_idle", {31'b0, irq}, 32'h0);
    applyStimulus(4'hC, 10'h003, 8);
    checkOutput("key1_irq", {31'b0, irq}, 32'h1);
    peek(KCTRL, "key1_kctrl", 32'h11);
    loadOp(KDATA, "key1_read", 32'h3);
    checkOutput("irq_after_read", {31'b0, irq}, 32'h0);

    applyStimulus(4'h8, 10'h003, 8);
    peek(KCTRL, "key2_kctrl", 32'h11);
    applyStimulus(4'h0, 10'h003, 5);
    loadOp(KDATA, "race_read", 32'h7);
    peek(KCTRL, "race_kctrl", 32'h11);
    peek(KDATA, "race_kdata", 32'hF);
    checkOutput("race_irq", {31'b0, irq}, 32'h1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
